// File: rtl/led_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with a tear-free,
// frame-synchronous double-buffered display word.
module led_scan_ctrl #(
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] disp_data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  digit_en,
  output logic [2:0]  cs_pointer,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        upd_pending
);

  localparam int                CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  function automatic logic [7:0] polarity(input logic [7:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic             wrap;

  logic [31:0] data_pend;
  logic [7:0]  dp_pend;
  logic [7:0]  en_pend;
  logic [31:0] data_a;
  logic [7:0]  dp_a;
  logic [7:0]  en_a;

  logic [3:0]  nib_p0;
  logic [7:0]  seg_p0;

  assign tick = (div_cnt == DIV_LAST);
  assign wrap = tick && (cs_pointer == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      cs_pointer <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      cs_pointer <= tick ? cs_pointer + 3'd1 : cs_pointer;
      frame_done <= wrap;
    end
  end

  // A write landing on the wrap edge bypasses the pending copy so the new
  // frame starts with it and nothing is left waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_pend   <= '0;
      dp_pend     <= '0;
      en_pend     <= '0;
      data_a      <= '0;
      dp_a        <= '0;
      en_a        <= '0;
      upd_pending <= 1'b0;
    end else begin
      if (wr_en) begin
        data_pend <= disp_data;
        dp_pend   <= dp_mask;
        en_pend   <= digit_en;
      end
      if (wrap) begin
        data_a      <= wr_en ? disp_data : data_pend;
        dp_a        <= wr_en ? dp_mask   : dp_pend;
        en_a        <= wr_en ? digit_en  : en_pend;
        upd_pending <= 1'b0;
      end else if (wr_en) begin
        upd_pending <= 1'b1;
      end
    end
  end

  // Stage p0: segment pattern for the digit currently selected
  always_comb begin
    nib_p0 = data_a[{cs_pointer, 2'b00} +: 4];
    seg_p0 = 8'h00;
    if (en_a[cs_pointer])
      seg_p0 = {dp_a[cs_pointer], hex7(nib_p0)};
  end

  // Stage p1: registered so seg aligns with the decoder's registered select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seg <= SEG_OFF;
    else
      seg <= polarity(seg_p0);
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized and directed bench for led_scan_ctrl against a frame-level model
// (active-high and active-low instances driven in parallel).
module tb_led_scan_ctrl;
  localparam int CD = 4;
  localparam int FRAME = 8 * CD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [31:0] disp_data = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  digit_en = '0;
  logic [2:0]  cs_pointer, cs_pointer_n;
  logic [7:0]  seg, seg_n;
  logic        frame_done, frame_done_n;
  logic        upd_pending, upd_pending_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_scan_ctrl #(.CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .disp_data(disp_data),
    .dp_mask(dp_mask), .digit_en(digit_en), .cs_pointer(cs_pointer),
    .seg(seg), .frame_done(frame_done), .upd_pending(upd_pending));

  led_scan_ctrl #(.CLK_DIV(CD), .SEG_ACTIVE_LOW(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .disp_data(disp_data),
    .dp_mask(dp_mask), .digit_en(digit_en), .cs_pointer(cs_pointer_n),
    .seg(seg_n), .frame_done(frame_done_n), .upd_pending(upd_pending_n));

  // Frame-level model: time since reset release, active/pending buffers
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          t;
  logic [31:0] a_data, p_data;
  logic [7:0]  a_dp, a_en, p_dp, p_en;
  logic        m_pend, m_fd;
  logic [7:0]  m_seg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %h, expected %h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    t = 0;
    a_data = '0; a_dp = '0; a_en = '0;
    p_data = '0; p_dp = '0; p_en = '0;
    m_pend = 1'b0; m_fd = 1'b0; m_seg = 8'h00;
  endtask

  task automatic model_step(input logic wr, input logic [31:0] d,
                            input logic [7:0] dp, input logic [7:0] en);
    int p;
    bit wrap_now;
    logic [3:0] nib;
    p = (t / CD) % 8;
    wrap_now = (t % FRAME) == FRAME - 1;
    nib = a_data[4*p +: 4];
    m_seg = a_en[p] ? {a_dp[p], hex_tab[nib]} : 8'h00;
    m_fd = wrap_now;
    if (wrap_now) begin
      if (wr) begin a_data = d;      a_dp = dp;   a_en = en;   end
      else    begin a_data = p_data; a_dp = p_dp; a_en = p_en; end
      m_pend = 1'b0;
    end else if (wr) begin
      m_pend = 1'b1;
    end
    if (wr) begin p_data = d; p_dp = dp; p_en = en; end
    t++;
  endtask

  task automatic check_outputs();
    check("ptr",          32'(cs_pointer),    32'((t / CD) % 8));
    check("ptr_n",        32'(cs_pointer_n),  32'((t / CD) % 8));
    check("seg",          32'(seg),           32'(m_seg));
    check("seg_n",        32'(seg_n),         32'(8'(~m_seg)));
    check("frame_done",   32'(frame_done),    32'(m_fd));
    check("frame_done_n", 32'(frame_done_n),  32'(m_fd));
    check("upd_pending",  32'(upd_pending),   32'(m_pend));
    check("upd_pending_n",32'(upd_pending_n), 32'(m_pend));
  endtask

  // Drive at the falling edge, step the model on the rising edge, compare at the next fall
  task automatic cycle(input logic wr, input logic [31:0] d,
                       input logic [7:0] dp, input logic [7:0] en);
    wr_en = wr; disp_data = d; dp_mask = dp; digit_en = en;
    @(posedge clk);
    model_step(wr, d, dp, en);
    @(negedge clk);
    wr_en = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, disp_data, dp_mask, digit_en);
  endtask

  task automatic idle_until_ptr(input int p);
    for (int i = 0; i < FRAME && ((t / CD) % 8) != p; i++) idle(1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_ptr",  32'(cs_pointer),  32'd0);
    check("rst_seg",  32'(seg),         32'h00);
    check("rst_segn", 32'(seg_n),       32'hFF);
    check("rst_fd",   32'(frame_done),  32'd0);
    check("rst_upd",  32'(upd_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // First write lands only at the first wrap; display blank until then
    cycle(1'b1, 32'h76543210, 8'h00, 8'hFF);
    idle(2 * FRAME + 4);

    // Tear-free update issued mid-frame
    idle_until_ptr(3);
    cycle(1'b1, 32'hFEDCBA98, 8'h00, 8'hFF);
    idle(2 * FRAME);

    // Write coincident with the wrap cycle
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) idle(1);
    cycle(1'b1, 32'h00000000, 8'h00, 8'hFF);
    idle(FRAME);

    // Blanking and decimal-point masks
    cycle(1'b1, 32'h88888888, 8'h0F, 8'hAA);
    idle(2 * FRAME);

    // Back-to-back writes: last one wins
    idle_until_ptr(2);
    cycle(1'b1, 32'h13579BDF, 8'hF0, 8'hFF);
    cycle(1'b1, 32'h2468ACE0, 8'h5A, 8'h7E);
    idle(2 * FRAME);

    // Mid-frame reset with a write pending
    idle_until_ptr(5);
    cycle(1'b1, 32'hDEADBEEF, 8'hFF, 8'hFF);
    do_reset();
    idle(2 * FRAME);

    // Randomized writes with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0)
        do_reset();
      else if ($urandom_range(0, 7) == 0)
        cycle(1'b1, $urandom, 8'($urandom), 8'($urandom));
      else
        idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
